// File: rtl/unstripe_align_if.sv
// Lane-side inputs and unstriper-side outputs of the lane alignment controller.
interface unstripe_align_if;
    logic [7:0] lane_data0, lane_data1, lane_data2, lane_data3;
    logic [3:0] lane_vld;
    logic [7:0] out_lane0, out_lane1, out_lane2, out_lane3;
    logic       unstrip_enb;
    logic       unstrip_clr;
    logic       aligned;
    logic       align_err;

    modport master (
        output lane_data0, lane_data1, lane_data2, lane_data3, lane_vld,
        input  out_lane0, out_lane1, out_lane2, out_lane3,
        input  unstrip_enb, unstrip_clr, aligned, align_err
    );

    modport slave (
        input  lane_data0, lane_data1, lane_data2, lane_data3, lane_vld,
        output out_lane0, out_lane1, out_lane2, out_lane3,
        output unstrip_enb, unstrip_clr, aligned, align_err
    );
endinterface

// File: rtl/unstripe_align_ctrl.sv
// Four-lane deskew controller ahead of the byte unstriper: per-lane FIFOs lock on a
// common COM symbol, then release one word per 4-clock unstriper rotation.
module unstripe_align_ctrl #(
    parameter logic [7:0] COM        = 8'hBC,
    parameter int         DEPTH      = 4,
    parameter int         MAX_SKEW   = 3,
    parameter int         LOSS_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    unstripe_align_if.slave bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam int          SW       = $clog2(MAX_SKEW + 2);
    localparam int          LW       = $clog2(LOSS_LIMIT + 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {HUNT, DESKEW, ALIGNED} state_t;

    state_t        state, state_nxt;
    logic [7:0]    lane_data [4];
    logic [7:0]    mem [4][DEPTH];
    logic [AW-1:0] wptr [4];
    logic [AW-1:0] rptr [4];
    logic [AW:0]   cnt [4];
    logic [7:0]    head [4];
    logic [7:0]    out_q [4];
    logic [3:0]    locked, lock_now, wr_req, empty, full, head_com;
    logic [1:0]    first_lane, first_sel, slot;
    logic [SW-1:0] skew_cnt;
    logic [LW-1:0] loss_cnt;
    logic          pop, underflow, overflow, skew_inc, skew_fail, loss_bad, loss_fail, fail;
    logic          enb_q, aligned_q, err_q, clr_q, clr_pend;

    assign lane_data[0] = bus.lane_data0;
    assign lane_data[1] = bus.lane_data1;
    assign lane_data[2] = bus.lane_data2;
    assign lane_data[3] = bus.lane_data3;

    always_comb begin
        state_nxt = state;
        first_sel = 2'd0;
        head      = '{default: '0};
        lock_now  = '0;
        wr_req    = '0;
        empty     = '0;
        full      = '0;
        head_com  = '0;
        for (int i = 0; i < 4; i++) begin
            head[i]     = mem[i][rptr[i]];
            empty[i]    = (cnt[i] == '0);
            full[i]     = (cnt[i] == FULL_CNT);
            head_com[i] = (head[i] == COM);
            lock_now[i] = (state != ALIGNED) && !locked[i] && bus.lane_vld[i] && (lane_data[i] == COM);
            wr_req[i]   = bus.lane_vld[i] && (locked[i] || lock_now[i]);
        end
        // Lowest-numbered lane wins when several lock together; it paces the skew count.
        for (int i = 3; i >= 0; i--)
            if (lock_now[i]) first_sel = 2'(i);

        pop       = (state == ALIGNED) && (slot == 2'd0) && !(|empty);
        underflow = (state == ALIGNED) && (slot == 2'd0) && (|empty);
        overflow  = |(wr_req & full & ~{4{pop}});
        skew_inc  = (state == DESKEW) && bus.lane_vld[first_lane];
        skew_fail = skew_inc && (int'(skew_cnt) + 1 > MAX_SKEW);
        loss_bad  = pop && (|head_com) && !(&head_com);
        loss_fail = loss_bad && (int'(loss_cnt) + 1 >= LOSS_LIMIT);
        fail      = underflow || overflow || skew_fail || loss_fail;

        if (fail)
            state_nxt = HUNT;
        else if (&(locked | lock_now))
            state_nxt = ALIGNED;
        else if ((state == HUNT) && (|lock_now))
            state_nxt = DESKEW;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= HUNT;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            locked     <= '0;
            first_lane <= '0;
            slot       <= '0;
            skew_cnt   <= '0;
            loss_cnt   <= '0;
            enb_q      <= 1'b0;
            aligned_q  <= 1'b0;
            err_q      <= 1'b0;
            clr_q      <= 1'b0;
            clr_pend   <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                wptr[i]  <= '0;
                rptr[i]  <= '0;
                cnt[i]   <= '0;
                out_q[i] <= '0;
            end
        end else begin
            err_q    <= fail;
            clr_q    <= fail || clr_pend;
            clr_pend <= 1'b0;
            if (fail) begin
                // Flush and unlock everything; out_q deliberately holds its last word.
                locked    <= '0;
                slot      <= '0;
                skew_cnt  <= '0;
                loss_cnt  <= '0;
                enb_q     <= 1'b0;
                aligned_q <= 1'b0;
                for (int i = 0; i < 4; i++) begin
                    wptr[i] <= '0;
                    rptr[i] <= '0;
                    cnt[i]  <= '0;
                end
            end else begin
                locked <= locked | lock_now;
                slot   <= (state == ALIGNED) ? slot + 2'd1 : 2'd0;
                if ((state == HUNT) && (|lock_now)) begin
                    first_lane <= first_sel;
                    skew_cnt   <= '0;
                end else if (skew_inc) begin
                    skew_cnt <= skew_cnt + 1'b1;
                end
                if (pop) begin
                    enb_q     <= 1'b1;
                    aligned_q <= 1'b1;
                    if (&head_com)     loss_cnt <= '0;
                    else if (loss_bad) loss_cnt <= loss_cnt + 1'b1;
                end
                for (int i = 0; i < 4; i++) begin
                    if (wr_req[i]) wptr[i] <= wptr[i] + 1'b1;
                    if (pop) begin
                        rptr[i]  <= rptr[i] + 1'b1;
                        out_q[i] <= head[i];
                    end
                    cnt[i] <= cnt[i] + (AW+1)'(wr_req[i]) - (AW+1)'(pop);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (wr_req[i] && !fail) mem[i][wptr[i]] <= lane_data[i];
    end

    assign bus.out_lane0   = out_q[0];
    assign bus.out_lane1   = out_q[1];
    assign bus.out_lane2   = out_q[2];
    assign bus.out_lane3   = out_q[3];
    assign bus.unstrip_enb = enb_q;
    assign bus.unstrip_clr = clr_q;
    assign bus.aligned     = aligned_q;
    assign bus.align_err   = err_q;
endmodule

// File: tb/tb_unstripe_align_ctrl.sv
// Scoreboard bench for unstripe_align_ctrl: directed lane streams, expected words and
// error/clear events queued up front, consumed by an unstriper-phase monitor.
module tb_unstripe_align_ctrl;
    localparam logic [1:0] EV_WORD = 2'd0;
    localparam logic [1:0] EV_ERR  = 2'd1;
    localparam logic [1:0] EV_CLR  = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] word;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    int         n_vec = 0;
    int         n_bad = 0;
    exp_t       exp_q[$];
    logic [1:0] phase = 2'd0;
    logic       prev_enb = 1'b0;

    unstripe_align_if bus ();

    unstripe_align_ctrl #(
        .COM(8'hBC), .DEPTH(4), .MAX_SKEW(3), .LOSS_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic string kname(input logic [1:0] k);
        case (k)
            EV_WORD: return "word";
            EV_ERR:  return "align_err";
            default: return "unstrip_clr";
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [31:0] word);
        exp_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: got %h, expected no event", kname(kind), word);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.word !== word) begin
                n_bad++;
                $display("FAIL event_%s: got %s %h, expected %s %h",
                         kname(e.kind), kname(kind), word, kname(e.kind), e.word);
            end
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [31:0] word);
        exp_t e;
        e.kind = kind;
        e.word = word;
        exp_q.push_back(e);
    endtask

    task automatic beat(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [7:0] d3, input logic [3:0] v);
        bus.lane_data0 = d0;
        bus.lane_data1 = d1;
        bus.lane_data2 = d2;
        bus.lane_data3 = d3;
        bus.lane_vld   = v;
        @(posedge clk); #1;
        bus.lane_vld = 4'h0;
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        repeat (6) @(posedge clk);
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Unstriper model: a word is taken when enb rises and every 4th clock after.
    always @(negedge clk) begin
        if (!rst) begin
            phase    = 2'd0;
            prev_enb = 1'b0;
        end else begin
            if (bus.align_err) begin
                expect_ev(EV_ERR, 32'h0);
                check("enb_low_on_err", {31'h0, bus.unstrip_enb}, 32'h0);
                check("aligned_low_on_err", {31'h0, bus.aligned}, 32'h0);
            end
            if (bus.unstrip_clr) expect_ev(EV_CLR, 32'h0);
            if (bus.unstrip_enb) begin
                phase = prev_enb ? phase + 2'd1 : 2'd0;
                if (phase == 2'd0)
                    expect_ev(EV_WORD, {bus.out_lane0, bus.out_lane1, bus.out_lane2, bus.out_lane3});
            end
            prev_enb = bus.unstrip_enb;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        bus.lane_data0 = 8'h00;
        bus.lane_data1 = 8'h00;
        bus.lane_data2 = 8'h00;
        bus.lane_data3 = 8'h00;
        bus.lane_vld   = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_lanes", {bus.out_lane0, bus.out_lane1, bus.out_lane2, bus.out_lane3}, 32'h0);
        check("reset_ctrl", {28'h0, bus.unstrip_enb, bus.unstrip_clr, bus.aligned, bus.align_err}, 32'h0);
        push(EV_CLR, 32'h0);
        rst = 1'b1;
        drain("drain_init");

        // All lanes COM together, one data word, then underflow.
        push(EV_WORD, 32'hBCBCBCBC);
        push(EV_WORD, 32'h01020304);
        push(EV_ERR, 32'h0);
        push(EV_CLR, 32'h0);
        beat(8'hBC, 8'hBC, 8'hBC, 8'hBC, 4'hF);
        beat(8'h01, 8'h02, 8'h03, 8'h04, 4'hF);
        drain("drain_basic");

        // Lane2 two bytes late: aligned after skew 2, stream undistorted.
        push(EV_WORD, 32'hBCBCBCBC);
        push(EV_WORD, 32'h40414243);
        push(EV_WORD, 32'h50515253);
        push(EV_ERR, 32'h0);
        push(EV_CLR, 32'h0);
        beat(8'h10, 8'h11, 8'h12, 8'h13, 4'hF);
        beat(8'h20, 8'h21, 8'h22, 8'h23, 4'hF);
        beat(8'hBC, 8'hBC, 8'h32, 8'hBC, 4'hF);
        beat(8'h40, 8'h41, 8'h33, 8'h43, 4'hF);
        beat(8'h50, 8'h51, 8'hBC, 8'h53, 4'hF);
        beat(8'h60, 8'h61, 8'h42, 8'h63, 4'hF);
        beat(8'h70, 8'h71, 8'h52, 8'h73, 4'hF);
        drain("drain_skew2");

        // Lane3 four bytes late: skew fail, never aligned.
        push(EV_ERR, 32'h0);
        push(EV_CLR, 32'h0);
        beat(8'hBC, 8'hBC, 8'hBC, 8'h00, 4'hF);
        beat(8'h01, 8'h02, 8'h03, 8'h04, 4'hF);
        beat(8'h11, 8'h12, 8'h13, 8'h14, 4'hF);
        beat(8'h21, 8'h22, 8'h23, 8'h24, 4'hF);
        beat(8'h31, 8'h32, 8'h33, 8'hBC, 4'hF);
        drain("drain_skew4");
        check("aligned_after_skew_fail", {31'h0, bus.aligned}, 32'h0);

        // Lane1 stops: underflow on the following slot-0 pop.
        push(EV_WORD, 32'hBCBCBCBC);
        push(EV_WORD, 32'h01020304);
        push(EV_WORD, 32'h11121314);
        push(EV_WORD, 32'h21222324);
        push(EV_ERR, 32'h0);
        push(EV_CLR, 32'h0);
        beat(8'hBC, 8'hBC, 8'hBC, 8'hBC, 4'hF);
        beat(8'h01, 8'h02, 8'h03, 8'h04, 4'hF);
        beat(8'h11, 8'h12, 8'h13, 8'h14, 4'hF);
        beat(8'h21, 8'h22, 8'h23, 8'h24, 4'hF);
        beat(8'h31, 8'h32, 8'h33, 8'h34, 4'b1101);
        drain("drain_underflow");

        // Four consecutive partial-COM words: error on the 4th pop.
        push(EV_WORD, 32'hBCBCBCBC);
        for (int k = 0; k < 3; k++) push(EV_WORD, 32'hBC111213);
        push(EV_ERR, 32'h0);
        push(EV_CLR, 32'h0);
        beat(8'hBC, 8'hBC, 8'hBC, 8'hBC, 4'hF);
        for (int k = 0; k < 4; k++) beat(8'hBC, 8'h11, 8'h12, 8'h13, 4'hF);
        drain("drain_loss");

        // Three bad words, an all-COM word, three more bad words: only underflow at the end.
        push(EV_WORD, 32'hBCBCBCBC);
        for (int k = 0; k < 3; k++) push(EV_WORD, 32'hBC212223);
        push(EV_WORD, 32'hBCBCBCBC);
        for (int k = 0; k < 3; k++) push(EV_WORD, 32'hBC212223);
        push(EV_ERR, 32'h0);
        push(EV_CLR, 32'h0);
        beat(8'hBC, 8'hBC, 8'hBC, 8'hBC, 4'hF);
        for (int k = 0; k < 3; k++) beat(8'hBC, 8'h21, 8'h22, 8'h23, 4'hF);
        beat(8'hBC, 8'hBC, 8'hBC, 8'hBC, 4'hF);
        for (int k = 0; k < 3; k++) beat(8'hBC, 8'h21, 8'h22, 8'h23, 4'hF);
        drain("drain_loss_clear");

        // Mid-stream asynchronous reset, then re-align on the next common COM.
        push(EV_WORD, 32'hBCBCBCBC);
        push(EV_WORD, 32'h01020304);
        beat(8'hBC, 8'hBC, 8'hBC, 8'hBC, 4'hF);
        beat(8'h01, 8'h02, 8'h03, 8'h04, 4'hF);
        check("aligned_before_reset", {31'h0, bus.aligned}, 32'h1);
        rst = 1'b0;
        #1;
        check("midreset_out_lanes", {bus.out_lane0, bus.out_lane1, bus.out_lane2, bus.out_lane3}, 32'h0);
        check("midreset_ctrl", {28'h0, bus.unstrip_enb, bus.unstrip_clr, bus.aligned, bus.align_err}, 32'h0);
        check("midreset_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        push(EV_CLR, 32'h0);
        push(EV_WORD, 32'hBCBCBCBC);
        push(EV_WORD, 32'hA1A2A3A4);
        push(EV_ERR, 32'h0);
        push(EV_CLR, 32'h0);
        rst = 1'b1;
        beat(8'h55, 8'h66, 8'h77, 8'h88, 4'hF);
        beat(8'hBC, 8'hBC, 8'hBC, 8'hBC, 4'hF);
        beat(8'hA1, 8'hA2, 8'hA3, 8'hA4, 4'hF);
        drain("drain_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/unstripe_align_ctrl.md
# unstripe_align_ctrl

Lane alignment and sequencing controller for the four-lane receive path, placed ahead of the byte unstriper. It captures per-lane bytes into small deskew FIFOs and locks all lanes on a common alignment symbol (COM). It then releases one byte per lane every 4 clocks, phased to the unstriper's lane0→lane3 rotation. It owns the unstriper's enable and clear, and drops to re-hunt on skew, underflow, overflow or repeated misalignment.

## Interface
- `COM`, 8'hBC, alignment symbol expected simultaneously on all lanes
- `DEPTH`, 4, per-lane FIFO depth; power of 2, ≥ 2
- `MAX_SKEW`, 3, max lane bytes between first and last lane locking; must be < DEPTH
- `LOSS_LIMIT`, 4, consecutive misaligned words before re-hunt
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `lane_data0`..`lane_data3` in 8 each: raw lane bytes
- `lane_vld` in 4: bit i qualifies `lane_data<i>`; at most one assertion per lane per 4 clocks
- `out_lane0`..`out_lane3` out 8 each: deskewed word, drives unstriper lane inputs
- `unstrip_enb` out 1: unstriper enable
- `unstrip_clr` out 1: one-cycle active-high clear to unstriper (sync reset)
- `aligned` out 1: high in ALIGNED
- `align_err` out 1: one-cycle pulse on any failure

## Operation
- Reset (`rst`=0): FSM=HUNT; FIFOs empty; slot=0; skew and loss counters 0; `out_lane*`=8'h00; `unstrip_enb`, `aligned`, `align_err`=0; `unstrip_clr`=1 for the first clock after reset release.
- HUNT: lane i not yet locked discards bytes until `lane_data<i>`==COM with `lane_vld[i]`. That COM is the first byte written and locks lane i. Bytes after lock are written every valid beat. Goes to DESKEW when the first lane locks, or straight to ALIGNED if all four lock on the same clock.
- DESKEW: skew counter increments on each valid beat of the earliest-locked lane after its COM. All four locked → ALIGNED. Skew counter > MAX_SKEW → fail.
- ALIGNED: 2-bit slot counter is 0 on entry and increments every clock. At slot 0:
  - All FIFOs non-empty → pop one byte from each into `out_lane0..3`.
  - Any FIFO empty → underflow fail.
- Word check on each pop:
  - All four bytes == COM → loss counter cleared.
  - Some but not all == COM → loss counter +1; reaching LOSS_LIMIT → fail.
  - No COM → no change.
- Overflow: a write to a full FIFO, in any state, → fail.
- Fail: `align_err` pulse; flush all FIFOs; unlock lanes; clear counters; `unstrip_enb`=0; `unstrip_clr`=1 for one clock; → HUNT. `out_lane*` hold their last value.
- Simultaneous events: fail has priority over pop and over lock. A write and a pop on the same lane on the same clock are both performed, with occupancy unchanged. A lane byte arriving on the fail clock is discarded, even if it is COM.

## Timing
- All outputs are registered.
- `aligned` and `unstrip_enb` rise on the clock edge that performs the first pop (edge E), when `out_lane*` also update.
- The unstriper samples lane0 at E+1, lane1 at E+2, lane2 at E+3 and lane3 at E+4. At E+4 the next pop updates `out_lane*`, and the unstriper samples the old lane3 value.
- `unstrip_enb` stays 1 continuously in ALIGNED. It falls on the fail edge, in the same cycle `unstrip_clr` rises.
- Latency: the last lane's COM written at edge W gives the first pop at W+1, since ALIGNED is entered at W and the pop happens in slot 0 of the next cycle.
- Reset asserted mid-operation clears everything immediately. No `align_err` pulse on reset.

## Test plan
- All lanes send COM together, then 8'h01..04 per lane at 4-clock spacing → `aligned`=1. `out_lane0..3` show BC,BC,BC,BC, then 01,02,03,04. The unstriper output stream is BC×4, 01, 02, 03, 04.
- Lane2 lags by 2 bytes, the others send 2 bytes then COM → lock after skew 2. The first popped word is all-BC and the stream is undistorted.
- Lane3 lags by MAX_SKEW+1 bytes → `align_err` pulse, `unstrip_clr` pulse, back in HUNT, `aligned` stays 0.
- In ALIGNED, lane1 stops sending valid bytes → underflow at the next slot-0 pop. `align_err`=1 for 1 clock, `unstrip_enb` 1→0 on the same edge.
- In ALIGNED, inject COM on lane0 only for 4 consecutive words → `align_err` fires on the 4th pop. Three bad words followed by one all-COM word → no error.
- Assert `rst`=0 mid-stream for 1 clock → all outputs 0 asynchronously. After release, `unstrip_clr` pulses once and the block re-aligns on the next common COM.
